// File: rtl/ttrng_pkg.sv
// Shared types, default parameter values and counter-width helper for the
// ttrng conditioner.
package ttrng_pkg;

  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_OUT_W      = 8;
  localparam int DEF_SAMPLE_DIV = 16;
  localparam int DEF_RCT_LIMIT  = 32;

  typedef enum logic {
    VN_IDLE       = 1'b0,
    VN_HAVE_FIRST = 1'b1
  } vn_state_t;

  // Bits needed for a counter that must reach max_val inclusive.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/ttrng_vn_debias.sv
// Von Neumann corrector: pairs consecutive samples, emits the first bit of an
// unequal pair, emits nothing for 00/11. clr abandons a half-collected pair.
module ttrng_vn_debias
  import ttrng_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic strobe,
  input  logic s,
  output logic emit,
  output logic rnd_bit
);

  vn_state_t state;
  vn_state_t state_next;
  logic      first_bit;
  logic      first_next;

  // pair state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= VN_IDLE;
      first_bit <= 1'b0;
    end else begin
      state     <= state_next;
      first_bit <= first_next;
    end
  end

  // next pair state
  always_comb begin
    state_next = state;
    first_next = first_bit;
    if (clr) begin
      state_next = VN_IDLE;
      first_next = 1'b0;
    end else if (strobe) begin
      case (state)
        VN_IDLE: begin
          state_next = VN_HAVE_FIRST;
          first_next = s;
        end
        VN_HAVE_FIRST: state_next = VN_IDLE;
        default:       state_next = VN_IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  // emit decode: only the second sample of an unequal pair produces a bit
  always_comb begin
    rnd_bit = first_bit;
    if (!clr && strobe && (state == VN_HAVE_FIRST) && (first_bit != s)) begin
      emit = 1'b1;
    end else begin
      emit = 1'b0;
    end
  end

endmodule

// File: rtl/ttrng_conditioner.sv
// TRNG conditioner: synchronise latch-cell sources, XOR-combine, von Neumann
// debias, pack into words behind valid/ready. Optional RCT: TTRNG_HEALTH_TEST_EN.
module ttrng_conditioner
  import ttrng_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int RCT_LIMIT  = DEF_RCT_LIMIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [NUM_SRC-1:0] raw_src,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               rnd_ready,
  output logic [OUT_W-1:0]   rnd_data,
  output logic               rnd_valid,
  output logic               health_fail,
  output logic               drop_pulse
);

  localparam int DIV_W = cnt_width(SAMPLE_DIV - 1);
  localparam int CNT_W = cnt_width(OUT_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;
  logic [DIV_W-1:0]   div_cnt;
  logic               strobe;
  logic               s;
  logic               emit;
  logic               vn_bit;
  logic [OUT_W-1:0]   shreg;
  logic [CNT_W-1:0]   cnt;
  logic               take;
  logic               out_free;
  logic               asm_full;
  logic               load_full;
  logic               load_direct;
  logic               drop;
  logic               health_hit;

  // two-flop synchronisers for the asynchronous latch outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= {NUM_SRC{1'b0}};
      sync2 <= {NUM_SRC{1'b0}};
    end else begin
      sync1 <= raw_src;
      sync2 <= sync1;
    end
  end

  // sample divider, parked at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= {DIV_W{1'b0}};
    end else if (!ena || (div_cnt == DIV_LAST)) begin
      div_cnt <= {DIV_W{1'b0}};
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign strobe = ena && (div_cnt == DIV_LAST);
  assign s      = ^(sync2 & src_mask);

  ttrng_vn_debias u_vn (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!ena),
    .strobe  (strobe),
    .s       (s),
    .emit    (emit),
    .rnd_bit (vn_bit)
  );

  // assembler / output-register decisions for this cycle
  always_comb begin
    take        = rnd_valid && rnd_ready;
    out_free    = !rnd_valid || take;
    asm_full    = (cnt == CNT_FULL);
    load_full   = asm_full && out_free;
    load_direct = emit && (cnt == CNT_LAST) && out_free;
    drop        = emit && asm_full && !out_free;
  end

  // assembler shift register and output holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= {OUT_W{1'b0}};
      cnt        <= {CNT_W{1'b0}};
      rnd_data   <= {OUT_W{1'b0}};
      rnd_valid  <= 1'b0;
      drop_pulse <= 1'b0;
    end else if (health_hit) begin
      shreg      <= {OUT_W{1'b0}};
      cnt        <= {CNT_W{1'b0}};
      rnd_data   <= {OUT_W{1'b0}};
      rnd_valid  <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (load_full) begin
        // a bit arriving on the same edge starts the next word
        rnd_data  <= shreg;
        rnd_valid <= 1'b1;
        shreg     <= emit ? {{(OUT_W-1){1'b0}}, vn_bit} : {OUT_W{1'b0}};
        cnt       <= emit ? CNT_W'(1) : {CNT_W{1'b0}};
      end else if (load_direct) begin
        rnd_data  <= {shreg[OUT_W-2:0], vn_bit};
        rnd_valid <= 1'b1;
        shreg     <= {OUT_W{1'b0}};
        cnt       <= {CNT_W{1'b0}};
      end else begin
        if (take) begin
          rnd_valid <= 1'b0;
        end
        if (emit && !asm_full) begin
          shreg <= {shreg[OUT_W-2:0], vn_bit};
          cnt   <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef TTRNG_HEALTH_TEST_EN
  localparam int RCT_W = cnt_width(RCT_LIMIT);
  localparam logic [RCT_W-1:0] RCT_LIM = RCT_W'(RCT_LIMIT);

  logic             prev_s;
  logic [RCT_W-1:0] rct_cnt;
  logic [RCT_W-1:0] rct_next;
  logic             rct_trip;

  // repetition count, saturating at the limit
  always_comb begin
    rct_next = rct_cnt;
    if (strobe) begin
      if (s == prev_s) begin
        rct_next = (rct_cnt == RCT_LIM) ? rct_cnt : rct_cnt + RCT_W'(1);
      end else begin
        rct_next = RCT_W'(1);
      end
    end else begin
      rct_next = rct_cnt;
    end
    rct_trip = strobe && (rct_next == RCT_LIM);
  end

  // RCT state and sticky failure flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_s      <= 1'b0;
      rct_cnt     <= {RCT_W{1'b0}};
      health_fail <= 1'b0;
    end else begin
      if (strobe) begin
        prev_s  <= s;
        rct_cnt <= rct_next;
      end
      if (rct_trip) begin
        health_fail <= 1'b1;
      end
    end
  end

  assign health_hit = health_fail || rct_trip;
`else
  assign health_fail = 1'b0;
  assign health_hit  = 1'b0;

  // the repetition threshold has no meaning without the health test
  if (RCT_LIMIT < 2) begin : g_rct_limit_unused
  end
`endif

endmodule

// File: tb/tb_ttrng_conditioner.sv
// Scoreboard bench for ttrng_conditioner at default parameters.
module tb_ttrng_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] raw_src;
  logic [3:0] src_mask;
  logic       rnd_ready;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       health_fail;
  logic       drop_pulse;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  ttrng_conditioner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .raw_src     (raw_src),
    .src_mask    (src_mask),
    .rnd_ready   (rnd_ready),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .health_fail (health_fail),
    .drop_pulse  (drop_pulse)
  );

  always #5 clk = ~clk;

  // output monitor: every presented word must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && rnd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word_unexpected: got %h, want no word", rnd_data);
      end else if (rnd_data !== exp_q[0]) begin
        bad++;
        $display("FAIL word_data: got %h, want %h", rnd_data, exp_q[0]);
      end
      if (rnd_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    rnd_ready = 1'b1;
    src_mask = 4'b0001;
    raw_src = 4'b0000;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // hold one sample value across one full divider period
  task automatic sample(input logic [3:0] v);
    raw_src = v;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic sample1(input logic b);
    logic [2:0] r;
    r = 3'($urandom);
    sample({r, b});
  endtask

  task automatic emit_bit1(input logic b);
    sample1(b);
    sample1(~b);
  endtask

  function automatic logic [3:0] par_val(input logic b);
    logic [3:0] v;
    v = 4'($urandom);
    if ((^v) != b) v[0] = ~v[0];
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; raw_src = 4'b0000; src_mask = 4'b0000; rnd_ready = 1'b0;
    #2;
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, want 0", rnd_valid); end
    total++; if (rnd_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h, want 00", rnd_data); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL reset_health: got %b, want 0", health_fail); end
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b, want 0", drop_pulse); end
  endtask

  task automatic test_basic();
    do_reset();
    exp_q.push_back(8'h55);
    for (int i = 0; i < 7; i++) emit_bit1(i[0]);
    sample1(1'b1);
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got %b, want 0", rnd_valid); end
    sample1(1'b0);
    total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: got %b, want 1", rnd_valid); end
    total++; if (rnd_data !== 8'h55) begin bad++; $display("FAIL basic_data: got %h, want 55", rnd_data); end
    @(posedge clk); #1;
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle: got %b, want 0", rnd_valid); end
  endtask

  task automatic test_no_emit();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample1(1'b0); sample1(1'b0);
      sample1(1'b1); sample1(1'b1);
      total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL noemit_valid: got %b, want 0", rnd_valid); end
    end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL noemit_health: got %b, want 0", health_fail); end
  endtask

  task automatic test_backpressure();
    logic [7:0] wa;
    logic [7:0] wb;
    do_reset();
    rnd_ready = 1'b0;
    wa = 8'hA5; wb = 8'h3C;
    exp_q.push_back(wa); exp_q.push_back(wb);
    for (int i = 7; i >= 0; i--) emit_bit1(wa[i]);
    total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid: got %b, want 1", rnd_valid); end
    for (int i = 7; i >= 0; i--) emit_bit1(wb[i]);
    total++; if (rnd_data !== wa) begin bad++; $display("FAIL bp_hold: got %h, want %h", rnd_data, wa); end
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL bp_no_drop: got %b, want 0", drop_pulse); end
    emit_bit1(1'b1);
    total++; if (drop_pulse !== 1'b1) begin bad++; $display("FAIL bp_drop: got %b, want 1", drop_pulse); end
    @(posedge clk); #1;
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL bp_drop_pulse: got %b, want 0", drop_pulse); end
    rnd_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL bp_no_bubble: got %b, want 1", rnd_valid); end
    total++; if (rnd_data !== wb) begin bad++; $display("FAIL bp_second: got %h, want %h", rnd_data, wb); end
    @(posedge clk); #1;
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b, want 0", rnd_valid); end
  endtask

  task automatic test_ena();
    logic [7:0] w;
    do_reset();
    w = 8'hB3;
    exp_q.push_back(w);
    emit_bit1(1'b1); emit_bit1(1'b0); emit_bit1(1'b1);
    sample1(1'b0);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      raw_src = 4'($urandom);
      @(posedge clk);
    end
    #1;
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL ena_idle: got %b, want 0", rnd_valid); end
    ena = 1'b1;
    for (int i = 4; i >= 1; i--) emit_bit1(w[i]);
    sample1(w[0]);
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL ena_early: got %b, want 0", rnd_valid); end
    sample1(~w[0]);
    total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL ena_word: got %b, want 1", rnd_valid); end
    total++; if (rnd_data !== w) begin bad++; $display("FAIL ena_data: got %h, want %h", rnd_data, w); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    do_reset();
    rnd_ready = 1'b0;
    exp_q.push_back(8'h96);
    w = 8'h96;
    for (int i = 7; i >= 0; i--) emit_bit1(w[i]);
    total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid: got %b, want 1", rnd_valid); end
    emit_bit1(1'b1); emit_bit1(1'b1); emit_bit1(1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b, want 0", rnd_valid); end
    total++; if (rnd_data !== 8'h00) begin bad++; $display("FAIL ar_data: got %h, want 00", rnd_data); end
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL ar_health: got %b, want 0", health_fail); end
    total++; if (drop_pulse !== 1'b0) begin bad++; $display("FAIL ar_drop: got %b, want 0", drop_pulse); end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rnd_ready = 1'b1;
    w = 8'h4E;
    exp_q.push_back(w);
    for (int i = 7; i >= 1; i--) emit_bit1(w[i]);
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL ar_fresh_early: got %b, want 0", rnd_valid); end
    emit_bit1(w[0]);
    total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL ar_fresh_word: got %b, want 1", rnd_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_mask();
    logic [6:0] rb;
    logic [7:0] w;
    do_reset();
    src_mask = 4'b1111;
    rb = 7'($urandom);
    w = {1'b1, rb};
    exp_q.push_back(w);
    sample(4'b1010); sample(4'b0000);
    sample(4'b0001); sample(4'b0011);
    for (int i = 6; i >= 1; i--) begin
      sample(par_val(rb[i]));
      sample(par_val(~rb[i]));
    end
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL mask_early: got %b, want 0", rnd_valid); end
    sample(par_val(rb[0]));
    sample(par_val(~rb[0]));
    total++; if (rnd_valid !== 1'b1) begin bad++; $display("FAIL mask_word: got %b, want 1", rnd_valid); end
    total++; if (rnd_data !== w) begin bad++; $display("FAIL mask_data: got %h, want %h", rnd_data, w); end
    @(posedge clk); #1;
  endtask

  task automatic test_health();
    logic exp_hf;
`ifdef TTRNG_HEALTH_TEST_EN
    exp_hf = 1'b1;
`else
    exp_hf = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 31; i++) sample1(1'b0);
    total++; if (health_fail !== 1'b0) begin bad++; $display("FAIL rct_before_limit: got %b, want 0", health_fail); end
    sample1(1'b0);
    total++; if (health_fail !== exp_hf) begin bad++; $display("FAIL rct_at_limit: got %b, want %b", health_fail, exp_hf); end
    total++; if (rnd_valid !== 1'b0) begin bad++; $display("FAIL rct_valid: got %b, want 0", rnd_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_emit();
    test_backpressure();
    test_ena();
    test_async_reset();
    test_mask();
    test_health();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_words: got %0d queued, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ttrng_conditioner.md
Name: ttrng_conditioner

Overview:
Parametrised successor to the single-bit TRNG stub. It samples NUM_SRC free-running SR-latch entropy sources, XOR-combines them, debiases the result with a von Neumann corrector, and packs the bits into OUT_W-bit words. Words are delivered over a valid/ready handshake. It sits between the latch-cell array and the tt_um top-level pin mapping.

Parameters:
NUM_SRC, 4, number of raw entropy inputs (1..8)
OUT_W, 8, output word width (2..16)
SAMPLE_DIV, 16, clocks per sample strobe (>=2)
RCT_LIMIT, 32, repetition-count health threshold (>=2, used only with the optional feature)

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  asynchronous, active-low reset
ena  in  1  block enable (TinyTapeout ena)
raw_src  in  NUM_SRC  asynchronous entropy bits from latch cells
src_mask  in  NUM_SRC  1 = source included in XOR
rnd_ready  in  1  consumer accepts word
rnd_data  out  OUT_W  random word
rnd_valid  out  1  rnd_data holds an unconsumed word
health_fail  out  1  sticky health-test failure
drop_pulse  out  1  one-cycle pulse when a debiased bit is discarded for backpressure

Behaviour:
- Reset (rst_n=0, async): all outputs 0; synchronisers, divider, pair, assembler and RCT state cleared.
- Synchroniser: each raw_src bit passes through a 2-flop synchroniser. Raw-to-sample latency is at least 2 clocks.
- Divider: counter runs 0..SAMPLE_DIV-1 and wraps. strobe=1 in the cycle where count==SAMPLE_DIV-1. While ena=0, the counter is held at 0, there are no strobes, and pair state is cleared. The assembler and output register keep their contents.
- Combine: on strobe, s = XOR of (sync & src_mask). If src_mask is all zero, s=0 (the health test then fails if the optional feature is enabled).
- Von Neumann: on the first strobe of a pair, store s and set have_first=1. On the second strobe, if first != s, emit bit=first; in all cases clear have_first. Pairs 00 and 11 emit nothing.
- Assembler: an emitted bit shifts in at the LSB (shreg <= {shreg[OUT_W-2:0], bit}) and cnt increments.
  - When cnt reaches OUT_W and the output register is empty, or is being consumed in the same cycle, transfer the word on the next clock: rnd_valid=1, cnt=0.
  - When the assembler is full and the output is occupied, the assembler holds. Further emitted bits are discarded and drop_pulse=1 for that cycle.
- Handshake: a transfer occurs when rnd_valid&&rnd_ready. rnd_data is stable while rnd_valid=1 and !rnd_ready. rnd_valid falls the cycle after a transfer unless a full assembler loads in that same edge; that gives back-to-back words with no bubble.
- Simultaneous events: emit with cnt==OUT_W-1 while the output is empty writes the word into the output register directly at that edge. Latency from the last pair strobe to rnd_valid is 1 clock.
- Throughput bound: at most 1 bit per 2*SAMPLE_DIV clocks.

Optional Feature:
Macro TTRNG_HEALTH_TEST_EN.
- Defined: a repetition-count test runs on s.
  - rct_cnt increments on each strobe where s equals the previous s, and resets to 1 otherwise.
  - When rct_cnt reaches RCT_LIMIT, health_fail=1 (sticky until rst_n).
  - While health_fail=1: rnd_valid is forced to 0, the output register and assembler are cleared, and no new words are produced.
- Not defined: no RCT logic is present, health_fail is tied to 0, and RCT_LIMIT is ignored.

Decomposition:
- Package ttrng_pkg:
  - typedef vn_state_t {VN_IDLE, VN_HAVE_FIRST}
  - function clog2-based width helper for cnt/divider/rct counters
  - default constants for the parameters
- One sub-module: ttrng_vn_debias (pair register plus emit logic, interface: strobe, s, emit, bit). Instantiated once.
- Synchronisers, divider, assembler and handshake live in the top of the block.

Test Plan:
1. Default params, src_mask=4'b0001, raw_src[0] driven per sample as pairs 01,10,01,10,01,10,01,10, rnd_ready=1 -> one word rnd_data=8'b01010101 with rnd_valid high for 1 cycle, 1 clock after the 16th strobe.
2. Raw pairs 00,11 repeated -> no emits and rnd_valid stays 0. With TTRNG_HEALTH_TEST_EN and a constant s, health_fail rises on the 32nd strobe.
3. rnd_ready=0; feed 16 emitting pairs -> first word is held stable with rnd_valid=1. Second word fills the assembler; the 17th emit gives drop_pulse=1. Raising rnd_ready then gives two consecutive words with no bubble.
4. ena=0 mid-pair (after first sample) -> divider frozen at 0 and pair discarded. Re-enable: the next pair starts fresh, and already-assembled bits are retained.
5. Assert rst_n=0 asynchronously mid-word with rnd_valid=1 -> rnd_valid, rnd_data, health_fail and drop_pulse are 0 immediately. After release, the first word needs a full 8 fresh emits.
6. src_mask=4'b1111, sources 1010/0000 across a pair -> s=0 then s=0 (XOR parity): no emit. Sources 0001/0011 -> s=1 then s=0: emits 1.
